// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier family.
//   state_e   : control FSM states of the iterative multiplier.
//   MUL_WIDTH : default operand width in bits; products are 2*MUL_WIDTH bits wide.
package mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_step.sv
// One radix-2 shift-add step of an unsigned multiplier (purely combinational).
// The upper half of p is the running accumulator. The lower half holds the
// multiplier bits that have not been consumed yet.
//   p      : current product register {acc, remaining multiplier bits}
//   mcand  : multiplicand
//   p_next : p after the conditional add of mcand and a one-bit right shift
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] p_next
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;

  // The extra MSB keeps the carry. The shift brings it back into the accumulator,
  // so the carry is never lost.
  assign addend = p[0] ? {1'b0, mcand} : '0;
  assign sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + addend;
  assign p_next = {sum, p[WIDTH-1:1]};

endmodule

// File: rtl/mul32_seq.sv
// Iterative radix-2 shift-add unsigned multiplier with valid/ready handshakes.
// Operands accepted on edge k give a product with out_valid from edge k+WIDTH on.
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : a/b valid           in_ready  : operands accepted this cycle
//   a, b       : unsigned operands (WIDTH bits each)
//   out_valid  : product valid        out_ready : consumer takes product
//   o_lo, o_hi : low/high halves of the 2*WIDTH-bit product (registered)
//   busy       : multiplication in progress
module mul32_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] p_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   o_lo_q, o_lo_d;
  logic [WIDTH-1:0]   o_hi_q, o_hi_d;

  logic accept;
  logic last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == RUN) && (cnt_q == CNT_LAST);

  mul_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_q),
    .mcand  (mcand_q),
    .p_next (p_step)
  );

  // State register together with the datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      o_lo_q  <= '0;
      o_hi_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // independent of statement order.
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      o_lo_q  <= o_lo_d;
      o_hi_q  <= o_hi_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first covers every path, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      // In DONE, in_ready follows out_ready, so in_valid here also means accept.
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. Acceptance can happen in IDLE or in DONE (back-to-back).
  always_comb begin
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    o_lo_d  = o_lo_q;
    o_hi_d  = o_hi_q;
    if (accept) begin
      mcand_d = a;
      p_d     = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      p_d   = p_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        // Output copy is loaded on entry to DONE. It holds past consumption.
        o_lo_d = p_step[WIDTH-1:0];
        o_hi_d = p_step[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Output logic, decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign o_lo = o_lo_q;
  assign o_hi = o_hi_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Self-checking bench for mul32_seq (WIDTH=32).
// Each accepted operand pair pushes its reference product onto a queue.
// Each consumed result pops the queue and compares against it.
module tb_mul32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] o_lo;
  logic [W-1:0] o_hi;
  logic         busy;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_results = 0;
  logic [2*W-1:0] sb[$];

  mul32_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o_lo      (o_lo),
    .o_hi      (o_hi),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] px;
    logic [2*W-1:0] py;
    px = {{W{1'b0}}, x};
    py = {{W{1'b0}}, y};
    return px * py;
  endfunction

  // One clock: settle inputs, record handshakes, cross the edge, then move #1 past it.
  task automatic tick();
    logic [2*W-1:0] exp_p;
    #1;
    if (rst) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(a, b));
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_unexpected: got result %h with nothing outstanding", {o_hi, o_lo});
        end else begin
          exp_p = sb.pop_front();
          if ({o_hi, o_lo} !== exp_p)
            $display("FAIL sb_product: got %h expected %h", {o_hi, o_lo}, exp_p);
          else
            n_pass++;
        end
        n_results++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance and then for out_valid. Returns at the
  // first DONE cycle without consuming. lat counts edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    int guard;
    a = x;
    b = y;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 3 * W) begin
      tick();
      guard++;
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < W + 8) begin
      tick();
      lat++;
    end
    n_checks++;
    if (!out_valid) $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    else n_pass++;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    else n_pass++;
    n_checks++;
    if ({o_hi, o_lo} !== '0) $display("FAIL reset_out: got %h required 0", {o_hi, o_lo});
    else n_pass++;
  endtask

  task automatic test_basic();
    a = 32'd7;
    b = 32'd6;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready: in_ready=%b required 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b001)
        $display("FAIL basic_run%0d: in_ready/out_valid/busy=%b required 001", i, {in_ready, out_valid, busy});
      else n_pass++;
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL basic_latency: out_valid=%b required 1", out_valid);
    else n_pass++;
    n_checks++;
    if (o_hi !== 32'd0 || o_lo !== 32'd42) $display("FAIL basic_value: got %h_%h required 0_2a", o_hi, o_lo);
    else n_pass++;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL basic_idle: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    else n_pass++;
  endtask

  task automatic test_corners();
    int lat;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    n_checks++;
    if (o_hi !== 32'hFFFF_FFFE || o_lo !== 32'h0000_0001)
      $display("FAIL max_value: got %h_%h required fffffffe_00000001", o_hi, o_lo);
    else n_pass++;
    n_checks++;
    if (lat !== W) $display("FAIL max_latency: got %0d required %0d", lat, W);
    else n_pass++;
    consume();
    run_op(32'h8000_0000, 32'd2, lat);
    n_checks++;
    if (o_hi !== 32'd1 || o_lo !== 32'd0) $display("FAIL msb_value: got %h_%h required 00000001_00000000", o_hi, o_lo);
    else n_pass++;
    consume();
    run_op(32'd0, 32'hDEAD_BEEF, lat);
    n_checks++;
    if (lat !== W || {o_hi, o_lo} !== '0) $display("FAIL zero_a: got %h lat %0d required 0 lat %0d", {o_hi, o_lo}, lat, W);
    else n_pass++;
    consume();
    run_op(32'h0001_2345, 32'd0, lat);
    n_checks++;
    if (lat !== W || {o_hi, o_lo} !== '0) $display("FAIL zero_b: got %h lat %0d required 0 lat %0d", {o_hi, o_lo}, lat, W);
    else n_pass++;
    consume();
  endtask

  task automatic test_stall();
    int lat;
    logic [2*W-1:0] exp_p;
    exp_p = model(32'hCAFE_BABE, 32'h0000_F00D);
    run_op(32'hCAFE_BABE, 32'h0000_F00D, lat);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {o_hi, o_lo} !== exp_p)
        $display("FAIL stall%0d: out_valid=%b in_ready=%b p=%h required 1 0 %h", i, out_valid, in_ready, {o_hi, o_lo}, exp_p);
      else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL stall_release: in_ready=%b required 1", in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL stall_idle: in_ready/out_valid/busy=%b required 100", {in_ready, out_valid, busy});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    int early;
    run_op(32'd11, 32'd13, lat);
    a = 32'd3;
    b = 32'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL b2b_run: busy=%b out_valid=%b required 1 0", busy, out_valid);
    else n_pass++;
    early = 0;
    for (int i = 1; i < W; i++) begin
      if (out_valid) early++;
      tick();
    end
    n_checks++;
    if (early !== 0) $display("FAIL b2b_early: out_valid seen %0d cycles early, required 0", early);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || o_hi !== 32'd0 || o_lo !== 32'd15)
      $display("FAIL b2b_value: out_valid=%b p=%h_%h required 1 0_f", out_valid, o_hi, o_lo);
    else n_pass++;
    consume();
  endtask

  task automatic test_abort();
    int lat;
    int stray;
    run_op(32'd3, 32'd3, lat);
    consume();
    a = 32'h1234_5678;
    b = 32'h9ABC_DEF0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || {o_hi, o_lo} !== '0)
      $display("FAIL abort_state: ctrl=%b p=%h required 100 0", {in_ready, out_valid, busy}, {o_hi, o_lo});
    else n_pass++;
    // Reset and in_valid on the same edge: the operands must not be taken.
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_vs_valid: busy=%b in_ready=%b required 0 1", busy, in_ready);
    else n_pass++;
    stray = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (out_valid) stray++;
      tick();
    end
    n_checks++;
    if (stray !== 0) $display("FAIL abort_stray: %0d out_valid cycles, required 0", stray);
    else n_pass++;
    run_op(32'h1234_5678, 32'h9ABC_DEF0, lat);
    n_checks++;
    if ({o_hi, o_lo} !== 64'h0B00_EA4E_242D_2080)
      $display("FAIL abort_fresh: got %h required 0b00ea4e242d2080", {o_hi, o_lo});
    else n_pass++;
    consume();
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'd1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_random();
    int sent;
    int start;
    int cyc;
    logic acc;
    sent  = 0;
    start = n_results;
    cyc   = 0;
    in_valid = 1'b0;
    while ((sent < 1000 || in_valid || sb.size() != 0) && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) == 0) begin
        a = rand_op();
        b = rand_op();
        in_valid = 1'b1;
      end
      #1;
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    n_checks++;
    if (n_results - start !== 1000 || sb.size() != 0)
      $display("FAIL random_count: results %0d outstanding %0d required 1000 0", n_results - start, sb.size());
    else n_pass++;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_stall();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
